// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_e  : controller states (IDLE, RUN, DONE)
//   MODE_ADD : sub input value selecting A + B + cin
//   MODE_SUB : sub input value selecting A - B
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used as the one arithmetic cell of the serial adder.
// Ports:
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. One operand bit per clock, LSB first, through
// a single full-adder cell. An accepted start captures the operands; the
// result appears WIDTH+1 cycles later together with a one-cycle done pulse.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start               : request, sampled only in IDLE
//   a, b, cin, sub      : operands and mode, captured on accepted start
//   busy                : high while bits are being processed
//   done                : one-cycle result-valid pulse
//   sum, cout, overflow : result, unsigned carry-out, signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic b_bit;
  logic fa_sum;
  logic fa_cout;

  // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry.
  assign b_bit = b_q[0] ^ (sub_q == MODE_SUB);

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_bit),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // NOTE: every next-state signal gets a default before the case statement so
  // no path leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        // Result bits enter at the MSB, so after WIDTH shifts bit 0 lands at 0.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB cell at this point.
          ovf_d   = carry_q ^ fa_cout;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      sub_q   <= MODE_ADD;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in for add mode, captured on accepted start.
REQ-008 SHALL have port sub  input  1  mode; 0 = A+B+cin, 1 = A-B; captured on accepted start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum  output  WIDTH  result, held stable between done and the next accepted start.
REQ-012 SHALL have port cout  output  1  unsigned carry-out of the final bit.
REQ-013 SHALL have port overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 Transitions SHALL be: IDLE -> RUN on start=1; RUN -> DONE after bit WIDTH-1 is processed; DONE -> IDLE unconditionally.
REQ-016 Start accepted at cycle 0 SHALL capture a, b, cin, and sub, clear the bit index, and assert busy from cycle 1.
REQ-017 RUN SHALL process exactly one bit per cycle, LSB first, through one full-adder cell; bit i is processed in cycle i+1.
REQ-018 The carry register SHALL be loaded with cin when sub=0, and with 1 when sub=1 (cin ignored).
REQ-019 The B bit SHALL be inverted when sub=1.
REQ-020 The carry register SHALL update each RUN cycle with the cell carry-out.
REQ-021 done SHALL be high for exactly cycle WIDTH+1, in state DONE; busy SHALL be low in DONE and IDLE.
REQ-022 sum, cout, and overflow SHALL be valid from cycle WIDTH+1, and SHALL hold until the next accepted start.
REQ-023 After an accepted start, sum contents are unspecified until done.
REQ-024 start SHALL be ignored while in RUN or DONE; operand changes during RUN SHALL have no effect.
REQ-025 start=1 in the cycle done is high SHALL be ignored; start held high SHALL be accepted in the following IDLE cycle.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; in sub mode, cout=1 SHALL mean no borrow (A >= B unsigned).
REQ-027 The bit index SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap mid-operation.

Reset
REQ-028 With reset_n=0 at a rising edge, the state SHALL become IDLE, and busy, done, sum, cout, overflow, carry, and index SHALL all be 0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; start in the same cycle as reset SHALL be ignored.
REQ-030 The first start SHALL be accepted on the first edge with reset_n=1.

Structure
REQ-031 A shared package serial_adder_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-032 A single combinational sub-module, fa_cell (a, b, cin -> sum, cout), SHALL be instantiated once.
REQ-033 The remaining logic SHALL be FSM, shift registers, and counter only.
REQ-034 The design SHALL contain no latches and no clocks other than clk.

Verification (WIDTH=8)
REQ-035 Add: a=0x0F, b=0x01, cin=0, sub=0, start for 1 cycle -> done exactly at cycle 9; sum=0x10, cout=0, overflow=0; busy high for cycles 1..8.
REQ-036 Carry/overflow: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, overflow=0; then a=0x7F, b=0x01, cin=0 -> sum=0x80, overflow=1.
REQ-037 Subtract: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0 (borrow), overflow=0; cin has no effect.
REQ-038 Ignore during run: start pulsed again at cycle 3 with a=0xAA -> result is that of the first operands; exactly one done pulse.
REQ-039 Reset mid-run: reset_n=0 at cycle 4 -> next cycle busy=0 and sum=0; no done pulse; a new start afterward completes normally.
REQ-040 Random: 1000 random operand/mode sets with back-to-back start held high -> every result matches the reference model; done spacing is 10 cycles.
